mux_stim_gen: RTL and testbench
===============================

// Module: mux_stim_gen
// PURPOSE
//  Synthesisable, clocked stimulus sequencer for N_IN:1 multiplexer test benches and BIST.
//  Drives mux data lines and select lines through a mode-selected pattern sequence.
//  Holds each pattern for HOLD cycles and supplies the expected mux output alongside it.
//  Sits between bench/BIST control (start/abort) and the mux under test plus its checker.
// PARAMETERS
//  N_IN        4       number of mux data inputs, legal range 2..8
//  HOLD        10      clock cycles each pattern is held, >=1
//  LFSR_STEPS  64      number of patterns issued in LFSR mode, >=1
//  LFSR_SEED   16'h1   LFSR load value at start; 0 is illegal (elaboration error)
//  (localparam SEL_W = clog2(N_IN); STEP_W = N_IN+SEL_W+1)
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      begin sequence; sampled only in IDLE
//  abort     in   1      terminate sequence; priority over everything except reset
//  mode      in   2      0 WALK, 1 EXHAUST, 2 LFSR, 3 reserved (behaves as WALK)
//  data_out  out  N_IN   mux data stimulus
//  sel_out   out  SEL_W  mux select stimulus; always < N_IN
//  exp_out   out  1      expected mux output = data_out[sel_out]
//  strobe    out  1      high on the last cycle of each hold; checker samples here
//  busy      out  1      high while in RUN
//  done      out  1      one-cycle pulse when a sequence completes normally
//  step_idx  out  STEP_W index of the pattern currently driven
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, hold_cnt 0, step 0, LFSR = LFSR_SEED.
//  - FSM states: IDLE -> RUN on start; RUN -> DONE after the last hold; RUN -> IDLE on abort.
//    DONE -> IDLE unconditionally after one cycle.
//  - Entering RUN (start sampled at edge t): latch mode; step 0 is visible from edge t+1.
//  - Each step is driven for HOLD cycles. strobe is high when hold_cnt==HOLD-1.
//    The step advances on the following edge.
//  - Total steps S: WALK 2*N_IN; EXHAUST N_IN*2^N_IN; LFSR LFSR_STEPS.
//  - After the last step's hold (edge t+S*HOLD): DONE for one cycle.
//    In DONE: done=1, busy=0, data/sel/exp/step_idx=0.
//  - WALK, step k: sel=k>>1; data = k[0] ? (1<<sel) : 0. Each channel is checked at 0 then 1.
//  - EXHAUST, step k: sel = k / 2^N_IN; data = k mod 2^N_IN (data fastest).
//  - LFSR: 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, loaded with LFSR_SEED at start.
//    Advanced once per step boundary.
//    data = lfsr[N_IN-1:0]; s = lfsr[15 -: SEL_W]; sel = (s>=N_IN) ? s-N_IN : s.
//  - All outputs are registered. exp_out is computed from the next-state data/sel, so it is
//    coherent with them in every cycle.
//  - start while busy or in DONE: ignored. mode changes during RUN: ignored (latched copy).
//  - abort in RUN: next edge -> IDLE, outputs 0, no done pulse. abort in IDLE/DONE: no effect.
//  - start and abort together in IDLE: abort wins; stays IDLE.
//  - rst_n low mid-sequence: immediate return to reset values; sequence not resumed.
//  - HOLD==1: strobe is constantly high in RUN; a new pattern is issued every cycle.
// STRUCTURE
//  - Package mux_stim_pkg: mode enum (MODE_WALK/EXHAUST/LFSR), FSM state enum
//    (ST_IDLE/RUN/DONE), LFSR tap constant 16'hB400.
//  - Sub-module mux_stim_lfsr: 16-bit Galois LFSR with load and advance enables.
//  - Top level: FSM, hold counter, step counter, per-mode pattern decode, output registers.
// TESTING (N_IN=4, HOLD=10 unless stated)
//  1. Reset while outputs nonzero -> all outputs 0 asynchronously; after release, IDLE, busy=0.
//  2. WALK start@t -> 8 steps. Step 3 (edges t+31..t+40): sel=1, data=4'b0010, exp=1.
//     strobe at t+40; done=1 at t+81 only.
//  3. EXHAUST -> 64 steps. Step 37: sel=2, data=4'b0101, exp=1. done at t+641.
//     exp_out==data_out[sel_out] every RUN cycle.
//  4. LFSR, LFSR_STEPS=5, SEED=16'h1 -> step0 data=4'b0001, sel=0, exp=1.
//     Following steps match a reference model; sel_out<4 always; done at t+51.
//  5. abort at step 2 of WALK -> next cycle busy=0, outputs 0, no done.
//     start while busy -> ignored, step_idx continues.
//  6. N_IN=3, HOLD=1, EXHAUST -> 24 steps, one per cycle, strobe constant; sel never 3.

Source files
------------

// File: rtl/mux_stim_pkg.sv
// -----------------------------------------------------------------------------
// mux_stim_pkg
// Shared types and constants for the mux stimulus sequencer.
//   mode_e   : pattern family selected at sequence start
//   state_e  : sequencer FSM states
//   LFSR_TAPS: Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   to_mode(): maps the raw 2-bit mode input onto mode_e (reserved code -> WALK)
// -----------------------------------------------------------------------------
package mux_stim_pkg;

   typedef enum logic [1:0] {
      MODE_WALK    = 2'd0,
      MODE_EXHAUST = 2'd1,
      MODE_LFSR    = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // The reserved encoding 2'd3 runs the walking pattern.
   function automatic mode_e to_mode(input logic [1:0] raw);
      case (raw)
         2'd1:    return MODE_EXHAUST;
         2'd2:    return MODE_LFSR;
         default: return MODE_WALK;
      endcase
   endfunction

endpackage

// File: rtl/mux_stim_lfsr.sv
// -----------------------------------------------------------------------------
// mux_stim_lfsr
// 16-bit Galois LFSR used as the pseudo-random pattern source.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (state returns to SEED)
//   load_i  in   reload SEED on the next edge (has priority over advance)
//   adv_i   in   advance one LFSR step on the next edge
//   lfsr_o  out  current LFSR state
// -----------------------------------------------------------------------------
module mux_stim_lfsr
   import mux_stim_pkg::*;
#(
   parameter logic [15:0] SEED = 16'h1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        adv_i,
   output logic [15:0] lfsr_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED;
      end else if (adv_i) begin
         lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together at the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mux_stim_gen.sv
// -----------------------------------------------------------------------------
// mux_stim_gen
// Clocked stimulus sequencer for N_IN:1 mux benches and BIST. Steps through a
// mode-selected pattern list, holding each pattern HOLD cycles, and supplies
// the expected mux output with it.
// Ports:
//   clk, rst_n  clock (rising edge) / asynchronous active-low reset
//   start       begin a sequence (only honoured in IDLE, loses to abort)
//   abort       end a running sequence at once, no done pulse
//   mode        0 WALK, 1 EXHAUST, 2 LFSR, 3 treated as WALK
//   data_out    mux data stimulus
//   sel_out     mux select stimulus, always < N_IN
//   exp_out     expected mux output, data_out[sel_out]
//   strobe      last cycle of each hold; checker samples here
//   busy        pattern being driven
//   done        one-cycle pulse after a completed sequence
//   step_idx    index of the pattern currently driven
// Timing: the internal FSM/counters lead the output registers by one cycle, so
// a start sampled at edge t shows step 0 from edge t+1 and done at t+S*HOLD+1.
// -----------------------------------------------------------------------------
module mux_stim_gen
   import mux_stim_pkg::*;
#(
   parameter int          N_IN       = 4,
   parameter int          HOLD       = 10,
   parameter int          LFSR_STEPS = 64,
   parameter logic [15:0] LFSR_SEED  = 16'h1,
   localparam int         SEL_W      = $clog2(N_IN),
   localparam int         STEP_W     = N_IN + SEL_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   output logic [N_IN-1:0]   data_out,
   output logic [SEL_W-1:0]  sel_out,
   output logic              exp_out,
   output logic              strobe,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_idx
);

   localparam int HOLD_W = $clog2(HOLD + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
   localparam logic [STEP_W-1:0] LAST_WALK = STEP_W'(2 * N_IN - 1);
   localparam logic [STEP_W-1:0] LAST_EXH  = STEP_W'(N_IN * (2 ** N_IN) - 1);
   localparam logic [STEP_W-1:0] LAST_LFSR = STEP_W'(LFSR_STEPS - 1);

   if (N_IN < 2 || N_IN > 8) begin : g_bad_n_in
      $error("mux_stim_gen: N_IN must be in 2..8");
   end
   if (HOLD < 1) begin : g_bad_hold
      $error("mux_stim_gen: HOLD must be >= 1");
   end
   if (LFSR_STEPS < 1 || LFSR_STEPS > 2 ** STEP_W) begin : g_bad_steps
      $error("mux_stim_gen: LFSR_STEPS out of range for step counter");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("mux_stim_gen: LFSR_SEED must be nonzero");
   end

   state_e              state_q;
   mode_e               mode_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [STEP_W-1:0]   step_q;

   logic [N_IN-1:0]     data_q;
   logic [SEL_W-1:0]    sel_q;
   logic                exp_q;
   logic                strobe_q;
   logic                busy_q;
   logic                done_q;
   logic [STEP_W-1:0]   step_idx_q;

   logic [15:0]         lfsr;
   logic                lfsr_load;
   logic                lfsr_adv;
   logic                hold_last;
   logic                last_step;
   logic [SEL_W-1:0]    lfsr_sel;
   logic [N_IN-1:0]     data_d;
   logic [SEL_W-1:0]    sel_d;
   logic                exp_d;

   assign hold_last = (hold_q == HOLD_LAST);
   assign lfsr_load = (state_q == ST_IDLE) && start && !abort;
   assign lfsr_adv  = (state_q == ST_RUN) && !abort && hold_last;

   mux_stim_lfsr #(
      .SEED   (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (lfsr_load),
      .adv_i  (lfsr_adv),
      .lfsr_o (lfsr)
   );

   // Pattern for the current internal step; registered into the outputs below.
   always_comb begin
      data_d    = '0;
      sel_d     = '0;
      lfsr_sel  = lfsr[15 -: SEL_W];
      last_step = 1'b0;
      case (mode_q)
         MODE_EXHAUST: begin
            // Data is the fast-moving field, select the slow one.
            data_d    = step_q[N_IN-1:0];
            sel_d     = step_q[N_IN +: SEL_W];
            last_step = (step_q == LAST_EXH);
         end
         MODE_LFSR: begin
            data_d = lfsr[N_IN-1:0];
            // Fold out-of-range selects back below N_IN with one subtraction.
            if ({1'b0, lfsr_sel} >= (SEL_W + 1)'(N_IN)) begin
               sel_d = lfsr_sel - SEL_W'(N_IN);
            end else begin
               sel_d = lfsr_sel;
            end
            last_step = (step_q == LAST_LFSR);
         end
         default: begin
            // Even step: channel at 0, odd step: same channel driven to 1.
            sel_d     = step_q[SEL_W:1];
            data_d    = step_q[0] ? (N_IN'(1) << sel_d) : '0;
            last_step = (step_q == LAST_WALK);
         end
      endcase
      exp_d = data_d[sel_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_WALK;
         hold_q     <= '0;
         step_q     <= '0;
         data_q     <= '0;
         sel_q      <= '0;
         exp_q      <= 1'b0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         step_idx_q <= '0;
      end else begin
         // Outputs idle at zero unless the RUN/DONE branches drive them.
         data_q     <= '0;
         sel_q      <= '0;
         exp_q      <= 1'b0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         step_idx_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_q <= ST_RUN;
                  mode_q  <= to_mode(mode);
                  hold_q  <= '0;
                  step_q  <= '0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
               end else begin
                  data_q     <= data_d;
                  sel_q      <= sel_d;
                  exp_q      <= exp_d;
                  strobe_q   <= hold_last;
                  busy_q     <= 1'b1;
                  step_idx_q <= step_q;
                  if (hold_last) begin
                     hold_q <= '0;
                     if (last_step) begin
                        state_q <= ST_DONE;
                     end else begin
                        step_q <= step_q + STEP_W'(1);
                     end
                  end else begin
                     hold_q <= hold_q + HOLD_W'(1);
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_out = data_q;
   assign sel_out  = sel_q;
   assign exp_out  = exp_q;
   assign strobe   = strobe_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign step_idx = step_idx_q;

endmodule

// File: tb/tb_mux_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_mux_stim_gen
// Two sequencers share one stimulus stream: A (N_IN=4, HOLD=10, 5 LFSR steps)
// and B (N_IN=3, HOLD=1, 64 LFSR steps). A behavioural model derives each
// cycle's expected outputs from the cycle distance to the accepted start edge;
// literal checks pin the model at hand-computed points.
// -----------------------------------------------------------------------------
module tb_mux_stim_gen;

   localparam int NA = 4, HA = 10, LA = 5, SA = 2;
   localparam int NB = 3, HB = 1,  LB = 64, SB = 2;

   typedef struct packed {
      int data;
      int sel;
      int ex;
      int strobe;
      int busy;
      int done;
      int step;
   } obs_t;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       start  = 1'b0;
   logic       abort  = 1'b0;
   logic [1:0] mode   = 2'd0;

   logic [3:0] data_a;
   logic [1:0] sel_a;
   logic       exp_a, strobe_a, busy_a, done_a;
   logic [6:0] step_a;
   logic [2:0] data_b;
   logic [1:0] sel_b;
   logic       exp_b, strobe_b, busy_b, done_b;
   logic [5:0] step_b;

   int n_vec  = 0;
   int n_err  = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   bit run_a = 1'b0, run_b = 1'b0;
   int t0_a = 0, t0_b = 0, md_a = 0, md_b = 0;

   always #5 clk = ~clk;

   mux_stim_gen #(.N_IN(NA), .HOLD(HA), .LFSR_STEPS(LA), .LFSR_SEED(16'h1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .data_out(data_a), .sel_out(sel_a), .exp_out(exp_a), .strobe(strobe_a),
      .busy(busy_a), .done(done_a), .step_idx(step_a)
   );

   mux_stim_gen #(.N_IN(NB), .HOLD(HB), .LFSR_STEPS(LB), .LFSR_SEED(16'h1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
      .data_out(data_b), .sel_out(sel_b), .exp_out(exp_b), .strobe(strobe_b),
      .busy(busy_b), .done(done_b), .step_idx(step_b)
   );

   // ---------------- model ----------------
   function automatic int steps_of(input int md, input int n, input int ls);
      case (md)
         1:       return n * (1 << n);
         2:       return ls;
         default: return 2 * n;
      endcase
   endfunction

   // LFSR value after k advances from seed 1.
   function automatic int lfsr_at(input int k);
      logic [15:0] r;
      r = 16'h0001;
      for (int i = 0; i < k; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
      end
      return int'(r);
   endfunction

   function automatic obs_t expect_of(input bit run, input int ns, input int md,
                                      input int n, input int hold, input int ls,
                                      input int selw);
      obs_t o;
      int   tot, k, h, r, s;
      o   = '0;
      tot = steps_of(md, n, ls) * hold;
      if (run && ns >= 1 && ns <= tot) begin
         k = (ns - 1) / hold;
         h = (ns - 1) % hold;
         case (md)
            1: begin
               o.sel  = k / (1 << n);
               o.data = k % (1 << n);
            end
            2: begin
               r      = lfsr_at(k);
               o.data = r % (1 << n);
               s      = r >> (16 - selw);
               o.sel  = (s >= n) ? s - n : s;
            end
            default: begin
               o.sel  = k / 2;
               o.data = (k % 2 == 1) ? (1 << o.sel) : 0;
            end
         endcase
         o.ex     = (o.data >> o.sel) & 1;
         o.strobe = (h == hold - 1) ? 1 : 0;
         o.busy   = 1;
         o.step   = k;
      end else if (run && ns == tot + 1) begin
         o.done = 1;
      end
      return o;
   endfunction

   task automatic model_edge(inout bit run, inout int t0, inout int md,
                             input int n, input int hold, input int ls);
      int ns, tot;
      bit aborted;
      ns      = cyc - t0;
      tot     = steps_of(md, n, ls) * hold;
      aborted = 1'b0;
      if (run && abort && ns >= 1 && ns <= tot) begin
         run     = 1'b0;
         aborted = 1'b1;
      end else if (run && ns >= tot + 2) begin
         run = 1'b0;
      end
      if (!run && !aborted && start && !abort) begin
         run = 1'b1;
         t0  = cyc;
         md  = (mode == 2'd3) ? 0 : int'(mode);
      end
   endtask

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) begin
         run_a = 1'b0;
         run_b = 1'b0;
      end else begin
         model_edge(run_a, t0_a, md_a, NA, HA, LA);
         model_edge(run_b, t0_b, md_b, NB, HB, LB);
      end
   end

   // ---------------- checking ----------------
   task automatic compare(input string tag, input obs_t e, input obs_t g);
      n_vec++;
      if (e != g) begin
         n_err++;
         $display("FAIL %s cyc=%0d got data=%0h sel=%0d exp=%0d strobe=%0d busy=%0d done=%0d step=%0d want data=%0h sel=%0d exp=%0d strobe=%0d busy=%0d done=%0d step=%0d",
                  tag, cyc, g.data, g.sel, g.ex, g.strobe, g.busy, g.done, g.step,
                  e.data, e.sel, e.ex, e.strobe, e.busy, e.done, e.step);
      end
   endtask

   always @(negedge clk) begin
      obs_t ea, eb, ga, gb;
      if (chk_en) begin
         ea = rst_n ? expect_of(run_a, cyc - t0_a, md_a, NA, HA, LA, SA) : '0;
         eb = rst_n ? expect_of(run_b, cyc - t0_b, md_b, NB, HB, LB, SB) : '0;
         ga = '{int'(data_a), int'(sel_a), int'(exp_a), int'(strobe_a),
                int'(busy_a), int'(done_a), int'(step_a)};
         gb = '{int'(data_b), int'(sel_b), int'(exp_b), int'(strobe_b),
                int'(busy_b), int'(done_b), int'(step_b)};
         compare("cycle_a", ea, ga);
         compare("cycle_b", eb, gb);
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic at_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [1:0] m, output int t);
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t     = cyc;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((busy_a || done_a || busy_b || done_b || run_a || run_b) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: got busy_a=%0d busy_b=%0d after %0d cycles, want 0", busy_a, busy_b, k);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", int'(busy_a), 0);
      check("rst_step", int'(step_a), 0);

      // WALK
      pulse_start(2'd0, t);
      at_edge(t + 31);
      check("walk_s3_sel",  int'(sel_a),  1);
      check("walk_s3_data", int'(data_a), 2);
      check("walk_s3_exp",  int'(exp_a),  1);
      check("walk_s3_idx",  int'(step_a), 3);
      at_edge(t + 40);
      check("walk_s3_strobe", int'(strobe_a), 1);
      at_edge(t + 80);
      check("walk_done_early", int'(done_a), 0);
      at_edge(t + 81);
      check("walk_done", int'(done_a), 1);
      check("walk_done_busy", int'(busy_a), 0);
      at_edge(t + 82);
      check("walk_done_late", int'(done_a), 0);
      wait_idle();

      // EXHAUST
      pulse_start(2'd1, t);
      at_edge(t + 24);
      check("b_exh_s23_sel",  int'(sel_b),  2);
      check("b_exh_s23_data", int'(data_b), 7);
      check("b_exh_strobe",   int'(strobe_b), 1);
      at_edge(t + 25);
      check("b_exh_done", int'(done_b), 1);
      at_edge(t + 371);
      check("exh_s37_sel",  int'(sel_a),  2);
      check("exh_s37_data", int'(data_a), 5);
      check("exh_s37_exp",  int'(exp_a),  1);
      at_edge(t + 641);
      check("exh_done", int'(done_a), 1);
      wait_idle();

      // LFSR
      pulse_start(2'd2, t);
      at_edge(t + 1);
      check("lfsr_s0_data", int'(data_a), 1);
      check("lfsr_s0_sel",  int'(sel_a),  0);
      check("lfsr_s0_exp",  int'(exp_a),  1);
      at_edge(t + 11);
      check("lfsr_s1_data", int'(data_a), 0);
      check("lfsr_s1_sel",  int'(sel_a),  2);
      at_edge(t + 51);
      check("lfsr_done", int'(done_a), 1);
      wait_idle();

      // abort, start while busy, mode change while running
      pulse_start(2'd0, t);
      at_edge(t + 12);
      start = 1'b1;
      mode  = 2'd2;
      @(negedge clk);
      start = 1'b0;
      at_edge(t + 15);
      check("busy_start_idx", int'(step_a), 1);
      at_edge(t + 24);
      check("pre_abort_idx", int'(step_a), 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", int'(busy_a), 0);
      check("abort_idx",  int'(step_a), 0);
      at_edge(t + 81);
      check("abort_no_done", int'(done_a), 0);
      wait_idle();

      // start together with abort in IDLE
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check("start_abort_idle", int'(busy_a), 0);

      // reserved mode runs WALK
      pulse_start(2'd3, t);
      at_edge(t + 31);
      check("rsv_s3_data", int'(data_a), 2);
      wait_idle();

      // asynchronous reset mid-sequence
      pulse_start(2'd1, t);
      at_edge(t + 105);
      check("pre_rst_busy", int'(busy_a), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", int'(busy_a), 0);
      check("async_rst_data", int'(data_a), 0);
      check("async_rst_idx",  int'(step_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_no_resume", int'(busy_a), 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
